// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the byte-stream boot loader.
// Memory command encodings match the ram port used by proc's fetch.
package boot_loader_pkg;

    localparam logic [1:0] RAM_NONE  = 2'd0;
    localparam logic [1:0] RAM_READ  = 2'd1;
    localparam logic [1:0] RAM_WRITE = 2'd2;

    localparam int unsigned MEM_SIZE_DEFAULT = 4096;

    // Left-align a right-packed word holding (fill+1) bytes; the low bytes become zero padding.
    function automatic logic [31:0] pad_word(input logic [31:0] w, input logic [1:0] fill);
        return w << {~fill, 3'b000};
    endfunction

endpackage

// File: rtl/boot_loader_if.sv
// Byte-stream input and memory write port of the boot loader, bundled as one interface.
interface boot_loader_if;
    import boot_loader_pkg::*;

    logic        byte_valid;
    logic [7:0]  byte_dat;
    logic        byte_ready;
    logic [1:0]  mem_do;
    logic [31:0] mem_addr;
    logic [31:0] mem_val;

    // Loader side.
    modport slave (
        input  byte_valid,
        input  byte_dat,
        output byte_ready,
        output mem_do,
        output mem_addr,
        output mem_val
    );

    // Stream source / memory observer side.
    modport master (
        output byte_valid,
        output byte_dat,
        input  byte_ready,
        input  mem_do,
        input  mem_addr,
        input  mem_val
    );

endinterface

// File: rtl/boot_loader_word_pack.sv
// Packs payload bytes big-endian into 32-bit words and issues one registered write pulse
// per full word or on the final byte (zero padded). Latency: 1 cycle byte->write.
module boot_word_pack
    import boot_loader_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_byte_vld,
    input  logic [7:0]  i_byte_dat,
    input  logic        i_last,
    input  logic [31:0] i_addr,
    output logic        o_flush,
    output logic [1:0]  o_mem_do,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_val
);

    logic [23:0] r_pack;
    logic [1:0]  r_fill;
    logic [1:0]  r_mem_do;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_val;
    logic [31:0] w_word;

    // Earlier bytes sit right-aligned in r_pack, so the new byte always lands in [7:0].
    assign w_word  = {r_pack, i_byte_dat};
    assign o_flush = i_byte_vld & ((r_fill == 2'd3) | i_last);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pack     <= '0;
            r_fill     <= '0;
            r_mem_do   <= RAM_NONE;
            r_mem_addr <= '0;
            r_mem_val  <= '0;
        end else begin
            r_mem_do <= RAM_NONE;
            if (i_byte_vld) begin
                if (o_flush) begin
                    r_pack     <= '0;
                    r_fill     <= '0;
                    r_mem_do   <= RAM_WRITE;
                    r_mem_addr <= i_addr;
                    r_mem_val  <= pad_word(w_word, r_fill);
                end else begin
                    r_pack <= w_word[23:0];
                    r_fill <= r_fill + 2'd1;
                end
            end
        end
    end

    assign o_mem_do   = r_mem_do;
    assign o_mem_addr = r_mem_addr;
    assign o_mem_val  = r_mem_val;

endmodule

// File: rtl/boot_loader.sv
// Framed image loader: 4-byte BE length, payload, XOR checksum; writes words and releases CPU reset.
// Ready is high only while loading (length/data/checksum); no other backpressure.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int unsigned MEM_SIZE  = MEM_SIZE_DEFAULT,
    parameter int unsigned BASE_ADDR = 0
)
(
    input  logic          i_clk,
    input  logic          i_rst,
    boot_loader_if.slave  bus,
    output logic          o_cpu_rst_n,
    output logic          o_done,
    output logic          o_err
);

    typedef enum logic [2:0] {
        S_LEN  = 3'd0,
        S_DATA = 3'd1,
        S_CSUM = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    localparam logic [31:0] LEN_MAX = 32'(MEM_SIZE - BASE_ADDR);
    localparam logic [31:0] BASE    = 32'(BASE_ADDR);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_ready;
    logic [31:0] r_len;
    logic [1:0]  r_len_cnt;
    logic [31:0] r_byte_cnt;
    logic [31:0] r_word_idx;
    logic [7:0]  r_csum;

    logic        w_acc;
    logic        w_data_acc;
    logic        w_last;
    logic        w_flush;
    logic [31:0] w_len_full;
    logic [31:0] w_addr;
    logic        w_ready_nxt;
    logic [1:0]  w_mem_do;
    logic [31:0] w_mem_addr;
    logic [31:0] w_mem_val;

    assign w_acc      = bus.byte_valid & r_ready;
    assign w_data_acc = w_acc & (r_state == S_DATA);
    assign w_len_full = {r_len[23:0], bus.byte_dat};
    assign w_last     = (r_byte_cnt + 32'd1) == r_len;
    assign w_addr     = BASE + {r_word_idx[29:0], 2'b00};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_LEN: begin
                if (w_acc && (r_len_cnt == 2'd3)) begin
                    if (w_len_full > LEN_MAX)
                        w_state_nxt = S_ERR;
                    else if (w_len_full == 32'd0)
                        w_state_nxt = S_CSUM;
                    else
                        w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_acc && w_last)
                    w_state_nxt = S_CSUM;
            end
            S_CSUM: begin
                if (w_acc)
                    w_state_nxt = (bus.byte_dat == r_csum) ? S_DONE : S_ERR;
            end
            default: w_state_nxt = r_state;
        endcase
    end

    // Ready is registered from the next state so it stays low through reset and rises one cycle later.
    assign w_ready_nxt = (w_state_nxt == S_LEN) || (w_state_nxt == S_DATA) ||
                         (w_state_nxt == S_CSUM);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_LEN;
            r_ready    <= 1'b0;
            r_len      <= '0;
            r_len_cnt  <= '0;
            r_byte_cnt <= '0;
            r_word_idx <= '0;
            r_csum     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= w_ready_nxt;
            if (w_acc && (r_state == S_LEN)) begin
                r_len     <= w_len_full;
                r_len_cnt <= r_len_cnt + 2'd1;
            end
            if (w_data_acc) begin
                r_csum     <= r_csum ^ bus.byte_dat;
                r_byte_cnt <= r_byte_cnt + 32'd1;
            end
            if (w_flush)
                r_word_idx <= r_word_idx + 32'd1;
        end
    end

    boot_word_pack u_pack (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_byte_vld (w_data_acc),
        .i_byte_dat (bus.byte_dat),
        .i_last     (w_last),
        .i_addr     (w_addr),
        .o_flush    (w_flush),
        .o_mem_do   (w_mem_do),
        .o_mem_addr (w_mem_addr),
        .o_mem_val  (w_mem_val)
    );

    assign bus.byte_ready = r_ready;
    assign bus.mem_do     = w_mem_do;
    assign bus.mem_addr   = w_mem_addr;
    assign bus.mem_val    = w_mem_val;

    assign o_done      = (r_state == S_DONE);
    assign o_err       = (r_state == S_ERR);
    assign o_cpu_rst_n = (r_state == S_DONE);

endmodule

// File: tb/tb_boot_loader.sv
// Directed test of boot_loader: table of framed images plus hand sequences for timing and abort.
module tb_boot_loader;
    import boot_loader_pkg::*;

    logic clk;
    logic rst;
    logic cpu_rst_n;
    logic done;
    logic err;

    boot_loader_if bus();

    boot_loader #(.MEM_SIZE(4096), .BASE_ADDR(0)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .bus         (bus),
        .o_cpu_rst_n (cpu_rst_n),
        .o_done      (done),
        .o_err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] cap_a[$];
    logic [31:0] cap_v[$];
    bit          bad_do = 1'b0;

    always @(negedge clk) begin
        if (!rst && bus.mem_do == RAM_WRITE) begin
            cap_a.push_back(bus.mem_addr);
            cap_v.push_back(bus.mem_val);
        end
        if (bus.mem_do == RAM_READ)
            bad_do = 1'b1;
    end

    typedef struct packed {
        logic [127:0] stream;   // first byte in [127:120]
        logic [7:0]   nb;
        logic [1:0]   nwr;
        logic [63:0]  addrs;    // write 0 in [63:32]
        logic [63:0]  vals;
        logic         exp_done;
        logic         exp_err;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.byte_valid = 1'b0;
        bus.byte_dat = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cap_a.delete();
        cap_v.delete();
    endtask

    // Returns #1 after the edge at which the byte was accepted.
    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited = 0;
        bus.byte_valid = 1'b1;
        bus.byte_dat = b;
        while (!bus.byte_ready && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!bus.byte_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: byte %h ready=%b required 1", b, bus.byte_ready);
        end else begin
            @(posedge clk);
            #1;
        end
        bus.byte_valid = 1'b0;
    endtask

    task automatic send_stream(input logic [127:0] s, input int nb, input bit gaps);
        logic [127:0] sv;
        sv = s;
        for (int i = 0; i < nb; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            send_byte(sv[127 - 8*i -: 8]);
        end
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [127:0] t2;
        vec_t v;
        rst = 1'b1;
        bus.byte_valid = 1'b0;
        bus.byte_dat = 8'h00;

        vecs[0] = '{stream: 128'h00000004_DEADBEEF_22000000_00000000, nb: 8'd9,  nwr: 2'd1,
                    addrs: {32'h0, 32'h0}, vals: {32'hDEADBEEF, 32'h0}, exp_done: 1'b1, exp_err: 1'b0};
        vecs[1] = '{stream: 128'h00000006_01020304_05060700_00000000, nb: 8'd11, nwr: 2'd2,
                    addrs: {32'h0, 32'h4}, vals: {32'h01020304, 32'h05060000}, exp_done: 1'b1, exp_err: 1'b0};
        vecs[2] = '{stream: 128'h00000004_DEADBEEF_23000000_00000000, nb: 8'd9,  nwr: 2'd1,
                    addrs: {32'h0, 32'h0}, vals: {32'hDEADBEEF, 32'h0}, exp_done: 1'b0, exp_err: 1'b1};
        vecs[3] = '{stream: 128'h00001001_00000000_00000000_00000000, nb: 8'd4,  nwr: 2'd0,
                    addrs: 64'h0, vals: 64'h0, exp_done: 1'b0, exp_err: 1'b1};
        vecs[4] = '{stream: 128'h00000000_00000000_00000000_00000000, nb: 8'd5,  nwr: 2'd0,
                    addrs: 64'h0, vals: 64'h0, exp_done: 1'b1, exp_err: 1'b0};

        // Reset state and ready rising one cycle after release.
        do_reset();
        chk("rst_ready",   {31'b0, bus.byte_ready}, 32'd0);
        chk("rst_mem_do",  {30'b0, bus.mem_do}, {30'b0, RAM_NONE});
        chk("rst_addr",    bus.mem_addr, 32'h0);
        chk("rst_val",     bus.mem_val, 32'h0);
        chk("rst_done",    {31'b0, done}, 32'd0);
        chk("rst_err",     {31'b0, err}, 32'd0);
        chk("rst_cpu_n",   {31'b0, cpu_rst_n}, 32'd0);
        @(posedge clk);
        #1;
        chk("ready_rise",  {31'b0, bus.byte_ready}, 32'd1);

        // Table-driven images.
        for (int k = 0; k < 5; k++) begin
            v = vecs[k];
            do_reset();
            send_stream(v.stream, int'(v.nb), 1'b0);
            settle();
            chk($sformatf("v%0d_done", k),  {31'b0, done}, {31'b0, v.exp_done});
            chk($sformatf("v%0d_err", k),   {31'b0, err}, {31'b0, v.exp_err});
            chk($sformatf("v%0d_cpu_n", k), {31'b0, cpu_rst_n}, {31'b0, v.exp_done});
            chk($sformatf("v%0d_ready", k), {31'b0, bus.byte_ready}, 32'd0);
            chk($sformatf("v%0d_nwr", k),   cap_a.size(), {30'b0, v.nwr});
            for (int w = 0; w < int'(v.nwr) && w < cap_a.size(); w++) begin
                chk($sformatf("v%0d_addr%0d", k, w), cap_a[w], v.addrs[63 - 32*w -: 32]);
                chk($sformatf("v%0d_val%0d", k, w),  cap_v[w], v.vals[63 - 32*w -: 32]);
            end
            if (v.nwr != 2'd0)
                chk($sformatf("v%0d_val_hold", k), bus.mem_val, v.vals[63 - 32*(int'(v.nwr) - 1) -: 32]);
        end

        // Write latency and write pulse coinciding with checksum acceptance.
        do_reset();
        send_stream(128'h00000004_DEADBE00_00000000_00000000, 7, 1'b0);
        chk("lat_idle", {30'b0, bus.mem_do}, {30'b0, RAM_NONE});
        send_byte(8'hEF);
        chk("lat_do",   {30'b0, bus.mem_do}, {30'b0, RAM_WRITE});
        chk("lat_val",  bus.mem_val, 32'hDEADBEEF);
        send_byte(8'h22);
        chk("lat_after_do", {30'b0, bus.mem_do}, {30'b0, RAM_NONE});
        chk("lat_done", {31'b0, done}, 32'd1);

        // Over-length error visible right after the 4th length byte.
        do_reset();
        send_stream(128'h00001001_00000000_00000000_00000000, 4, 1'b0);
        chk("len_err_now", {31'b0, err}, 32'd1);
        chk("len_err_do",  {30'b0, bus.mem_do}, {30'b0, RAM_NONE});

        // Gapped image aborted by reset after payload byte 3, then resent in full.
        t2 = 128'h00000006_01020304_05060700_00000000;
        do_reset();
        send_stream(t2, 7, 1'b1);
        do_reset();
        send_stream(t2, 11, 1'b1);
        settle();
        chk("abort_nwr",  cap_a.size(), 32'd2);
        if (cap_a.size() == 2) begin
            chk("abort_a0", cap_a[0], 32'h0);
            chk("abort_v0", cap_v[0], 32'h01020304);
            chk("abort_a1", cap_a[1], 32'h4);
            chk("abort_v1", cap_v[1], 32'h05060000);
        end
        chk("abort_done", {31'b0, done}, 32'd1);
        chk("never_read", {31'b0, bad_do}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
